alu_cmd_sequencer: RTL

Upstream command front-end for the combinational 8-bit ALU (eight_bit_alu). It receives 3-byte command frames (opcode, A, B) over a byte-wide valid/ready stream and drives registered operands and opcode into the ALU. It waits a programmable settle time, captures the ALU result and swap flag, and presents a response with valid/ready handshake. It rejects illegal opcodes and divide-by-zero before the ALU result is used.

---
 rtl/alu_pkg.sv | 22 ++
 rtl/eight_bit_alu.sv | 35 +++
 rtl/alu_cmd_sequencer.sv | 98 +++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcode constants, sequencer states and opcode legality check
package alu_pkg;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_MUL = 3'b010;
   localparam logic [2:0] OP_DIV = 3'b011;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      GET_A = 3'd1,
      GET_B = 3'd2,
      EXEC  = 3'd3,
      RESP  = 3'd4
   } state_t;

   // Only codes 0..3 exist in the ALU; every other byte value is rejected.
   function automatic logic is_legal_opcode(input logic [7:0] opc);
      return (opc[7:3] == 5'd0) && (opc[2] == 1'b0);
   endfunction

endpackage

// File: rtl/eight_bit_alu.sv
// rtl/eight_bit_alu.sv - combinational 8-bit ALU; sub/div order operands larger-first and flag the swap
module eight_bit_alu
   import alu_pkg::*;
(
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic [2:0] code,
   output logic [7:0] result,
   output logic       swap
);

   logic [7:0] hi;
   logic [7:0] lo;

   always_comb begin
      hi     = (a < b) ? b : a;
      lo     = (a < b) ? a : b;
      result = 8'h00;
      swap   = 1'b0;
      case (code)
         OP_ADD: result = a + b;
         OP_SUB: begin
            swap   = (a < b);
            result = hi - lo;
         end
         OP_MUL: result = a * b;
         OP_DIV: begin
            swap   = (a < b);
            result = (lo == 8'h00) ? 8'h00 : hi / lo;
         end
         default: result = 8'h00;
      endcase
   end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - collects opcode/A/B byte frames, drives the ALU, waits settle time, returns response
module alu_cmd_sequencer
   import alu_pkg::*;
#(
   parameter int SETTLE_CYCLES = 1,
   parameter int CNT_W         = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [7:0]       in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [7:0]       alu_a,
   output logic [7:0]       alu_b,
   output logic [2:0]       alu_code,
   input  logic [7:0]       alu_result,
   input  logic             alu_swap,
   output logic [7:0]       out_result,
   output logic             out_swap,
   output logic             out_err,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CNT_W-1:0] cmd_count
);

   localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

   state_t     state;
   state_t     state_nxt;
   logic [7:0] opc_reg;
   logic [3:0] settle_cnt;
   logic       in_fire;
   logic       frame_err;

   // Gated by rst_n so nothing is offered while reset is held.
   assign in_ready = rst_n && (state == IDLE || state == GET_A || state == GET_B);
   assign in_fire  = in_valid && in_ready;

   assign frame_err = !is_legal_opcode(opc_reg) ||
                      (opc_reg[2:0] == OP_DIV && (alu_a == 8'h00 || alu_b == 8'h00));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid) state_nxt = GET_A;
         GET_A:   if (in_valid) state_nxt = GET_B;
         GET_B:   if (in_valid) state_nxt = EXEC;
         EXEC:    if (settle_cnt == 4'd0) state_nxt = RESP;
         RESP:    if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         opc_reg    <= 8'h00;
         alu_a      <= 8'h00;
         alu_b      <= 8'h00;
         alu_code   <= OP_ADD;
         settle_cnt <= 4'd0;
         out_result <= 8'h00;
         out_swap   <= 1'b0;
         out_err    <= 1'b0;
         out_valid  <= 1'b0;
         cmd_count  <= '0;
      end else begin
         case (state)
            IDLE:  if (in_fire) opc_reg <= in_data;
            GET_A: if (in_fire) alu_a <= in_data;
            GET_B: if (in_fire) begin
               alu_b      <= in_data;
               // Illegal frames still run through EXEC, so park the ALU on a defined code.
               alu_code   <= is_legal_opcode(opc_reg) ? opc_reg[2:0] : OP_ADD;
               settle_cnt <= SETTLE_LOAD;
            end
            EXEC: begin
               if (settle_cnt == 4'd0) begin
                  out_result <= frame_err ? 8'h00 : alu_result;
                  out_swap   <= frame_err ? 1'b0 : alu_swap;
                  out_err    <= frame_err;
                  out_valid  <= 1'b1;
                  if (cmd_count != '1) cmd_count <= cmd_count + 1'b1;
               end else begin
                  settle_cnt <= settle_cnt - 4'd1;
               end
            end
            RESP: if (out_ready) out_valid <= 1'b0;
            default: ;
         endcase
      end
   end

endmodule
